// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider with shadowed period/high-time registers,
// per-channel tick, and a global sync that phase-aligns all channels.
module clock_divider_multi #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned WIDTH           = 28,
  parameter int unsigned DEFAULT_DIVISOR = 5,
  localparam int unsigned SelW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock_in,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] enable,
  input  logic                sync,
  input  logic                load,
  input  logic [SelW-1:0]     load_sel,
  input  logic [WIDTH-1:0]    load_divisor,
  input  logic [WIDTH-1:0]    load_high,
  output logic [CHANNELS-1:0] clock_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  localparam logic [WIDTH-1:0] DefDiv  = WIDTH'(DEFAULT_DIVISOR);
  localparam logic [WIDTH-1:0] DefHigh = WIDTH'(DEFAULT_DIVISOR / 2);

  logic [31:0] sel_ext;
  logic        sel_valid;

  assign sel_ext   = 32'(load_sel);
  assign sel_valid = (sel_ext < CHANNELS);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [WIDTH-1:0] counter_q, counter_d;
    logic [WIDTH-1:0] active_div_q, active_div_d;
    logic [WIDTH-1:0] active_high_q, active_high_d;
    logic [WIDTH-1:0] shadow_div_q, shadow_div_d;
    logic [WIDTH-1:0] shadow_high_q, shadow_high_d;
    logic             pending_q, pending_d;
    logic             clock_out_q, clock_out_d;
    logic             tick_q, tick_d;
    logic             run;
    logic             wrap;
    logic             load_hit;
    logic             boundary;

    always_comb begin
      // A stopped (div 0) or disabled channel sits at a permanent period boundary.
      run      = enable[g] && (active_div_q != '0);
      wrap     = run && (counter_q >= active_div_q - WIDTH'(1));
      load_hit = load && sel_valid && (sel_ext == 32'(g));
      boundary = !run || wrap || sync;

      counter_d     = boundary ? '0 : counter_q + WIDTH'(1);
      clock_out_d   = run && (counter_q < active_high_q);
      tick_d        = run && (counter_q == '0);
      active_div_d  = active_div_q;
      active_high_d = active_high_q;
      shadow_div_d  = shadow_div_q;
      shadow_high_d = shadow_high_q;
      pending_d     = pending_q;

      if (pending_q && boundary) begin
        active_div_d  = shadow_div_q;
        active_high_d = shadow_high_q;
        pending_d     = 1'b0;
      end
      // A load racing an apply lands in the shadow and waits for the next boundary.
      if (load_hit) begin
        shadow_div_d  = load_divisor;
        shadow_high_d = load_high;
        pending_d     = 1'b1;
      end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
        counter_q     <= '0;
        active_div_q  <= DefDiv;
        active_high_q <= DefHigh;
        shadow_div_q  <= DefDiv;
        shadow_high_q <= DefHigh;
        pending_q     <= 1'b0;
        clock_out_q   <= 1'b0;
        tick_q        <= 1'b0;
      end else begin
        counter_q     <= counter_d;
        active_div_q  <= active_div_d;
        active_high_q <= active_high_d;
        shadow_div_q  <= shadow_div_d;
        shadow_high_q <= shadow_high_d;
        pending_q     <= pending_d;
        clock_out_q   <= clock_out_d;
        tick_q        <= tick_d;
      end
    end

    assign clock_out[g] = clock_out_q;
    assign tick[g]      = tick_q;
    assign pending[g]   = pending_q;
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench for clock_divider_multi: directed scenarios plus random traffic,
// checked against a period/position reference model.
module tb_clock_divider_multi;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 28;

  logic          clock_in = 1'b0;
  logic          reset_n  = 1'b0;
  logic [CH-1:0] enable   = '0;
  logic          sync     = 1'b0;
  logic          load     = 1'b0;
  logic [1:0]    load_sel = '0;
  logic [W-1:0]  load_divisor = '0;
  logic [W-1:0]  load_high    = '0;
  logic [CH-1:0] clock_out;
  logic [CH-1:0] tick;
  logic [CH-1:0] pending;

  clock_divider_multi dut (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .enable       (enable),
    .sync         (sync),
    .load         (load),
    .load_sel     (load_sel),
    .load_divisor (load_divisor),
    .load_high    (load_high),
    .clock_out    (clock_out),
    .tick         (tick),
    .pending      (pending)
  );

  always #5 clock_in = ~clock_in;

  typedef struct packed {
    logic [CH-1:0] clk;
    logic [CH-1:0] tck;
    logic [CH-1:0] pnd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: position within the current period plus live/shadow settings.
  int m_pos[CH], m_div[CH], m_high[CH], m_sdiv[CH], m_shigh[CH];
  bit m_pend[CH];

  logic pat_clk[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic pat_tck[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_pos[c]  = 0;
      m_div[c]  = 5;
      m_sdiv[c] = 5;
      m_high[c] = 2;
      m_shigh[c] = 2;
      m_pend[c] = 1'b0;
    end
  endfunction

  function automatic exp_t model_step(input logic [CH-1:0] en, input bit sy, input bit ld,
                                      input int sel, input int dv, input int hi);
    exp_t e;
    for (int c = 0; c < CH; c++) begin
      bit live;
      bit restart;
      live     = en[c] && (m_div[c] != 0);
      e.clk[c] = live && (m_pos[c] < m_high[c]);
      e.tck[c] = live && (m_pos[c] == 0);
      restart  = !live || sy || (m_pos[c] == m_div[c] - 1);
      m_pos[c] = restart ? 0 : m_pos[c] + 1;
      if (m_pend[c] && restart) begin
        m_div[c]  = m_sdiv[c];
        m_high[c] = m_shigh[c];
        m_pend[c] = 1'b0;
      end
      if (ld && sel == c) begin
        m_sdiv[c]  = dv;
        m_shigh[c] = hi;
        m_pend[c]  = 1'b1;
      end
      e.pnd[c] = m_pend[c];
    end
    return e;
  endfunction

  // Drive one cycle of stimulus at the falling edge and queue the expected result.
  task automatic step(input logic [CH-1:0] en, input bit sy, input bit ld,
                      input int sel, input int dv, input int hi);
    @(negedge clock_in);
    enable       = en;
    sync         = sy;
    load         = ld;
    load_sel     = 2'(sel);
    load_divisor = W'(dv);
    load_high    = W'(hi);
    exp_q.push_back(model_step(en, sy, ld, sel, dv, hi));
    @(posedge clock_in);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('1, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic check_default_pattern(input string name);
    for (int k = 0; k < 10; k++) begin
      step('1, 1'b0, 1'b0, 0, 0, 0);
      #2;
      chk({name, "_clk"}, clock_out, {CH{pat_clk[k % 5]}});
      chk({name, "_tick"}, tick, {CH{pat_tck[k % 5]}});
    end
  endtask

  // Monitor: every output cycle is compared against the oldest queued expectation.
  initial begin
    forever begin
      @(posedge clock_in);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_clock_out", clock_out, e.clk);
        chk("sb_tick", tick, e.tck);
        chk("sb_pending", pending, e.pnd);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    chk("reset_clock_out", clock_out, '0);
    chk("reset_tick", tick, '0);
    chk("reset_pending", pending, '0);
    @(negedge clock_in);
    reset_n = 1'b1;

    // Defaults: 1,1,0,0,0 on every channel.
    check_default_pattern("default");

    // Mid-period load on channel 1.
    idle(2);
    step('1, 1'b0, 1'b1, 1, 8, 3);
    #2;
    chk("ch1_pending_set", pending, 4'b0010);
    idle(24);

    // Load exactly in channel 1's wrap cycle, then overwrite before the next wrap.
    for (int k = 0; k < 50 && (m_pos[1] != m_div[1] - 1); k++) idle(1);
    step('1, 1'b0, 1'b1, 1, 4, 1);
    step('1, 1'b0, 1'b1, 1, 6, 6);
    idle(30);

    // Channel 0 degenerates: div 1, stopped, restart with period 3.
    step('1, 1'b0, 1'b1, 0, 1, 1);
    idle(8);
    step('1, 1'b0, 1'b1, 0, 0, 1);
    idle(6);
    step('1, 1'b0, 1'b1, 0, 3, 1);
    idle(10);

    // Channels 0..2 at 3/5/7, then sync with a pending load on channel 2.
    step('1, 1'b0, 1'b1, 0, 3, 1);
    step('1, 1'b0, 1'b1, 1, 5, 2);
    step('1, 1'b0, 1'b1, 2, 7, 3);
    idle(23);
    step('1, 1'b0, 1'b1, 2, 4, 2);
    step('1, 1'b1, 1'b0, 0, 0, 0);
    #2;
    chk("sync_applies_pending", {3'b000, pending[2]}, 4'b0000);
    step('1, 1'b0, 1'b0, 0, 0, 0);
    #2;
    chk("sync_ticks_aligned", tick, 4'hF);
    idle(12);

    // Random traffic, including disables and syncs.
    for (int i = 0; i < 1500; i++) begin
      logic [CH-1:0] en;
      for (int c = 0; c < CH; c++) en[c] = ($urandom_range(0, 9) != 0);
      step(en, ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 9)),
           int'($urandom_range(0, 10)));
    end

    // Asynchronous reset mid-period with a pending load.
    idle(3);
    step('1, 1'b0, 1'b1, 1, 9, 4);
    idle(1);
    #3;
    reset_n = 1'b0;
    enable  = '0;
    load    = 1'b0;
    sync    = 1'b0;
    #1;
    chk("async_reset_clock_out", clock_out, '0);
    chk("async_reset_tick", tick, '0);
    chk("async_reset_pending", pending, '0);
    exp_q.delete();
    model_reset();
    @(negedge clock_in);
    @(negedge clock_in);
    reset_n = 1'b1;
    check_default_pattern("after_reset");

    repeat (2) @(posedge clock_in);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
